sigmoid_inverse: RTL and testbench

Pipelined inverse of the team's piecewise-linear (PWL) sigmoid. It maps a fixed-point activation y back to the pre-activation x using the same five segments, breakpoints and constants as the forward sigmoid. Because every slope is a power of two, the inversion needs only subtractors and shifters. It sits on the GRU debug/calibration path behind a valid/ready stream and gives one result per cycle with 2-cycle latency.

---
 rtl/sigmoid_inverse.sv | 165 ++++++++++++++++
 tb/tb_sigmoid_inverse.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_inverse.sv
// sigmoid_inverse: two-stage pipelined inverse of the five-segment PWL sigmoid.
// Maps a signed Q(INT.FRAC) activation y back to the pre-activation x using
// power-of-two slopes, so the datapath is subtract-then-shift only.
// Optional build macro SIGMOID_INV_STATS_EN adds the sat_count output, which
// counts delivered saturated results.
module sigmoid_inverse #(
   parameter int INT_WIDTH  = 8,
   parameter int FRAC_WIDTH = 8,
   parameter int WIDTH      = INT_WIDTH + FRAC_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_x,
   output logic             out_sat,
   output logic [2:0]       out_seg
`ifdef SIGMOID_INV_STATS_EN
   ,
   output logic [15:0]      sat_count
`endif
);

   typedef enum logic [2:0] {
      SEG_LO = 3'd0,
      SEG_1  = 3'd1,
      SEG_2  = 3'd2,
      SEG_3  = 3'd3,
      SEG_4  = 3'd4,
      SEG_5  = 3'd5,
      SEG_HI = 3'd6
   } seg_t;

   // Breakpoints on y (real value * 2^FRAC_WIDTH, truncated)
   localparam logic signed [WIDTH-1:0] ZERO = '0;
   localparam logic signed [WIDTH-1:0] B1   = WIDTH'((5  << FRAC_WIDTH) >> 6);  // 0.078125
   localparam logic signed [WIDTH-1:0] B2   = WIDTH'((1  << FRAC_WIDTH) >> 2);  // 0.25
   localparam logic signed [WIDTH-1:0] B3   = WIDTH'((3  << FRAC_WIDTH) >> 2);  // 0.75
   localparam logic signed [WIDTH-1:0] B4   = WIDTH'((59 << FRAC_WIDTH) >> 6);  // 0.921875
   localparam logic signed [WIDTH-1:0] B5   = WIDTH'(1 << FRAC_WIDTH);          // 1.0

   // Per-segment y offsets
   localparam logic signed [WIDTH-1:0] C1   = WIDTH'((5  << FRAC_WIDTH) >> 5);  // 0.15625
   localparam logic signed [WIDTH-1:0] C2   = WIDTH'((3  << FRAC_WIDTH) >> 3);  // 0.375
   localparam logic signed [WIDTH-1:0] C3   = WIDTH'((1  << FRAC_WIDTH) >> 1);  // 0.5
   localparam logic signed [WIDTH-1:0] C4   = WIDTH'((5  << FRAC_WIDTH) >> 3);  // 0.625
   localparam logic signed [WIDTH-1:0] C5   = WIDTH'((27 << FRAC_WIDTH) >> 5);  // 0.84375

   // Output clamp limits +/-5.0, at word width and at shifter width
   localparam logic signed [WIDTH-1:0] X_POS = WIDTH'(5 << FRAC_WIDTH);
   localparam logic signed [WIDTH-1:0] X_NEG = -X_POS;
   localparam logic signed [WIDTH+5:0] W_POS = (WIDTH+6)'(X_POS);
   localparam logic signed [WIDTH+5:0] W_NEG = (WIDTH+6)'(X_NEG);

   logic                    adv1;
   logic                    adv2;
   logic                    s1_valid;
   logic                    s2_valid;
   logic signed [WIDTH-1:0] s1_y;
   seg_t                    s1_seg;
   logic signed [WIDTH-1:0] y_in;
   seg_t                    seg_in;

   logic signed [WIDTH-1:0] off;
   logic [2:0]              sh;
   logic signed [WIDTH:0]   diff;
   logic signed [WIDTH+5:0] wide;
   logic signed [WIDTH-1:0] x_next;
   logic                    sat_next;

   assign y_in      = in_y;
   assign adv2      = !s2_valid || out_ready;
   assign adv1      = !s1_valid || adv2;
   assign in_ready  = adv1;
   assign out_valid = s2_valid;

   // Segment select on the incoming sample, first match wins
   always_comb begin
      if (y_in <= ZERO)     seg_in = SEG_LO;
      else if (y_in < B1)   seg_in = SEG_1;
      else if (y_in < B2)   seg_in = SEG_2;
      else if (y_in <= B3)  seg_in = SEG_3;
      else if (y_in < B4)   seg_in = SEG_4;
      else if (y_in < B5)   seg_in = SEG_5;
      else                  seg_in = SEG_HI;
   end

   // Stage 1: capture y and its segment whenever the stage may advance
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_y     <= '0;
         s1_seg   <= SEG_LO;
      end else if (adv1) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_y   <= y_in;
            s1_seg <= seg_in;
         end
      end
   end

   // Subtract the segment offset, scale by the inverse slope, then clamp to +/-5.0
   always_comb begin
      off = C3;
      sh  = 3'd2;
      case (s1_seg)
         SEG_1:   begin off = C1; sh = 3'd5; end
         SEG_2:   begin off = C2; sh = 3'd3; end
         SEG_4:   begin off = C4; sh = 3'd3; end
         SEG_5:   begin off = C5; sh = 3'd5; end
         default: ;
      endcase
      diff     = (WIDTH+1)'(s1_y) - (WIDTH+1)'(off);
      wide     = (WIDTH+6)'(diff) <<< sh;
      sat_next = 1'b0;
      if (s1_seg == SEG_LO) begin
         x_next   = X_NEG;
         sat_next = 1'b1;
      end else if (s1_seg == SEG_HI) begin
         x_next   = X_POS;
         sat_next = 1'b1;
      end else if (wide > W_POS) begin
         x_next   = X_POS;
         sat_next = 1'b1;
      end else if (wide < W_NEG) begin
         x_next   = X_NEG;
         sat_next = 1'b1;
      end else begin
         x_next   = WIDTH'(wide);
      end
   end

   // Stage 2: output register, held while the consumer stalls
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_valid <= 1'b0;
         out_x    <= '0;
         out_sat  <= 1'b0;
         out_seg  <= '0;
      end else if (adv2) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_x   <= x_next;
            out_sat <= sat_next;
            out_seg <= s1_seg;
         end
      end
   end

`ifdef SIGMOID_INV_STATS_EN
   // Count delivered saturated results, sticking at all-ones
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sat_count <= '0;
      end else if (s2_valid && out_ready && out_sat && (sat_count != '1)) begin
         sat_count <= sat_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sigmoid_inverse.sv
// tb_sigmoid_inverse: directed and round-trip checks for sigmoid_inverse (Q8.8).
// Expected results are queued on accept and compared on delivery.
module tb_sigmoid_inverse;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_y;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_x;
   logic        out_sat;
   logic [2:0]  out_seg;
`ifdef SIGMOID_INV_STATS_EN
   logic [15:0] sat_count;
`endif

   typedef struct {
      logic [15:0] x;
      logic        sat;
      logic [2:0]  seg;
      bit          rt;
      int          rtx;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   mon_xo;
   bit   mon_ok;
   int   compared   = 0;
   int   mismatched = 0;

   sigmoid_inverse #(.INT_WIDTH(8), .FRAC_WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_y      (in_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_x     (out_x),
      .out_sat   (out_sat),
      .out_seg   (out_seg)
`ifdef SIGMOID_INV_STATS_EN
      ,
      .sat_count (sat_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference inverse, written straight from the segment table
   function automatic exp_t model(input logic [15:0] yv);
      int   y;
      int   x;
      exp_t e;
      y     = $signed(yv);
      e.sat = 1'b0;
      e.rt  = 1'b0;
      e.rtx = 0;
      if (y <= 0)        begin x = -1280;          e.seg = 3'd0; e.sat = 1'b1; end
      else if (y < 20)   begin x = (y - 40)  * 32; e.seg = 3'd1; end
      else if (y < 64)   begin x = (y - 96)  * 8;  e.seg = 3'd2; end
      else if (y <= 192) begin x = (y - 128) * 4;  e.seg = 3'd3; end
      else if (y < 236)  begin x = (y - 160) * 8;  e.seg = 3'd4; end
      else if (y < 256)  begin x = (y - 216) * 32; e.seg = 3'd5; end
      else               begin x = 1280;           e.seg = 3'd6; e.sat = 1'b1; end
      if (x > 1280)  begin x = 1280;  e.sat = 1'b1; end
      if (x < -1280) begin x = -1280; e.sat = 1'b1; end
      e.x = 16'(x);
      return e;
   endfunction

   // Forward PWL sigmoid in Q8.8 (floor rounding on the slope shift)
   function automatic int fwd(input int x);
      if (x < -608)      return (x >>> 5) + 40;
      else if (x < -256) return (x >>> 3) + 96;
      else if (x <= 256) return (x >>> 2) + 128;
      else if (x <= 608) return (x >>> 3) + 160;
      else               return (x >>> 5) + 216;
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic exp_t mk(input logic [15:0] x, input logic sat, input logic [2:0] seg);
      exp_t e;
      e.x = x; e.sat = sat; e.seg = seg; e.rt = 1'b0; e.rtx = 0;
      return e;
   endfunction

   task automatic send_e(input logic [15:0] y, input exp_t e);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_y     = y;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept", 32'(in_ready), 32'd1);
      if (in_ready) sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(sb.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   // Latency probe right after send_e returns with an otherwise empty pipe
   task automatic check_latency();
      @(negedge clk);
      chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
   endtask

   // Scoreboard: compare every delivered result against the oldest queued expectation
   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         chk("unexpected_output", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("out_x",   32'(out_x),   32'(mon_e.x));
            chk("out_sat", 32'(out_sat), 32'(mon_e.sat));
            chk("out_seg", 32'(out_seg), 32'(mon_e.seg));
            if (mon_e.rt) begin
               mon_xo = $signed(out_x);
               if (out_seg == 3'd3) mon_ok = (mon_xo == (mon_e.rtx & ~3));
               else                 mon_ok = (iabs(mon_xo - mon_e.rtx) <= 32);
               chk("round_trip", 32'(mon_ok), 32'd1);
            end
         end
      end
   end

   logic [15:0] dir_y   [9] = '{16'h00C0, 16'h0014, 16'h00EC, 16'h0013, 16'h00C1,
                                16'h0000, 16'h8000, 16'h0100, 16'h7FFF};
   logic [15:0] dir_x   [9] = '{16'h0100, 16'hFDA0, 16'h0280, 16'hFD60, 16'h0108,
                                16'hFB00, 16'hFB00, 16'h0500, 16'h0500};
   logic        dir_sat [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   logic [2:0]  dir_seg [9] = '{3'd3, 3'd2, 3'd5, 3'd1, 3'd4, 3'd0, 3'd0, 3'd6, 3'd6};

   initial begin
      exp_t e;
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_y      = '0;
      out_ready = 1'b1;

      // Reset state
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_x",     32'(out_x),     32'd0);
      chk("rst_out_sat",   32'(out_sat),   32'd0);
      chk("rst_out_seg",   32'(out_seg),   32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready",  32'(in_ready),  32'd1);
`ifdef SIGMOID_INV_STATS_EN
      chk("rst_sat_count", 32'(sat_count), 32'd0);
`endif

      // 0.5 maps to 0 with two-cycle latency
      send_e(16'h0080, mk(16'h0000, 1'b0, 3'd3));
      check_latency();

      // Directed segment and clamp values, back to back
      for (int i = 0; i < 9; i++) send_e(dir_y[i], mk(dir_x[i], dir_sat[i], dir_seg[i]));
      drain();
`ifdef SIGMOID_INV_STATS_EN
      chk("sat_count_after_clamps", 32'(sat_count), 32'd4);
`endif

      // Back-pressure: two accepts fill the pipe, the third waits
      out_ready = 1'b0;
      send_e(16'h0080, mk(16'h0000, 1'b0, 3'd3));
      send_e(16'h00C0, mk(16'h0100, 1'b0, 3'd3));
      in_valid = 1'b1;
      in_y     = 16'h0014;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stall_in_ready",  32'(in_ready),  32'd0);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_out_x",     32'(out_x),     32'h0000);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      send_e(16'h0014, mk(16'hFDA0, 1'b0, 3'd2));
      drain();

      // Asynchronous reset with two samples in flight
      out_ready = 1'b0;
      send_e(16'h00C0, mk(16'h0100, 1'b0, 3'd3));
      send_e(16'h0014, mk(16'hFDA0, 1'b0, 3'd2));
      #3;
      reset = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_x",     32'(out_x),     32'd0);
      chk("midrst_out_sat",   32'(out_sat),   32'd0);
      chk("midrst_out_seg",   32'(out_seg),   32'd0);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      reset     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
`ifdef SIGMOID_INV_STATS_EN
      chk("midrst_sat_count", 32'(sat_count), 32'd0);
`endif
      send_e(16'h00C1, mk(16'h0108, 1'b0, 3'd4));
      check_latency();

      // Round trip over [-4.0, +4.0], streamed at full rate
      for (int x = -1024; x <= 1024; x++) begin
         e     = model(16'(fwd(x)));
         e.rtx = x;
         e.rt  = !((iabs(iabs(x) - 608) <= 40) || (iabs(iabs(x) - 256) <= 40));
         send_e(16'(fwd(x)), e);
      end
      drain();

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
